// File: rtl/transport_pkg.sv
// Shared transport-layer constants: header bytes, session strobe codes and
// the packetizer state encoding.
package transport_pkg;

  localparam logic [7:0] HDR_CTRL            = 8'h40;
  localparam logic [7:0] HDR_AUDIO           = 8'h80;
  localparam int         DEFAULT_PACKET_SIZE = 16;

  typedef enum logic [1:0] {
    SESS_NONE  = 2'b00,
    SESS_CTRL  = 2'b01,
    SESS_AUDIO = 2'b10
  } sess_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CTRL_HI,
    ST_CTRL_LO,
    ST_AUD_HI,
    ST_AUD_LO,
    ST_PAD
  } state_e;

  function automatic logic [7:0] header_for(input sess_e kind);
    return (kind == SESS_CTRL) ? HDR_CTRL : HDR_AUDIO;
  endfunction

endpackage

// File: rtl/audio_word_fifo.sv
// First-word-fall-through FIFO for 16-bit audio samples; dout shows the
// oldest word whenever the FIFO is not empty.
module audio_word_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [15:0]      din,
  input  logic             pop,
  output logic [15:0]      dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_do_push = push && !r_full;
  assign w_do_pop  = pop && !r_empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and leaving it out keeps it a RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/transport_send.sv
// Transmit-side packetizer: frames control words and audio samples into
// fixed-size byte packets and streams them one byte per cycle.
module transport_send
  import transport_pkg::*;
#(
  parameter int PACKET_SIZE = DEFAULT_PACKET_SIZE,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_valid,
  input  logic [15:0] ctrl_data,
  output logic        ctrl_ready,
  input  logic        audio_valid,
  input  logic [15:0] audio_data,
  output logic        audio_ready,
  input  logic        net_busy,
  output logic        send_signal,
  output logic [7:0]  packet_out,
  output logic        busy
);

  localparam int         AUDIO_WORDS = (PACKET_SIZE - 2) / 2;
  localparam int         CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_BYTE   = 8'(PACKET_SIZE - 1);
  localparam logic [7:0] LAST_AUD_LO = 8'(PACKET_SIZE - 2);

  state_e           r_state;
  sess_e            r_kind;
  logic [7:0]       r_byte_cnt;
  logic             r_send;
  logic [7:0]       r_out;
  logic             r_busy;
  logic             r_ctrl_ready;
  logic [15:0]      r_ctrl_word;

  logic             w_push;
  logic             w_pop;
  logic [15:0]      w_fifo_dout;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_audio_start;

  assign w_push        = audio_valid && !w_fifo_full;
  assign w_pop         = (r_state == ST_AUD_LO) && !net_busy && !w_fifo_empty;
  assign w_audio_start = (w_fifo_count >= CNT_W'(AUDIO_WORDS));

  audio_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (audio_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // The pending-control register is "full" exactly while ctrl_ready is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl_ready <= 1'b1;
      r_ctrl_word  <= '0;
    end else if (ctrl_valid && r_ctrl_ready) begin
      r_ctrl_ready <= 1'b0;
      r_ctrl_word  <= ctrl_data;
    end else if (r_state == ST_CTRL_LO && !net_busy) begin
      r_ctrl_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_kind     <= SESS_NONE;
      r_byte_cnt <= '0;
      r_send     <= 1'b0;
      r_out      <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_send <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (!r_ctrl_ready) begin
          r_state    <= ST_HDR;
          r_kind     <= SESS_CTRL;
          r_byte_cnt <= '0;
          r_busy     <= 1'b1;
        end else if (w_audio_start) begin
          r_state    <= ST_HDR;
          r_kind     <= SESS_AUDIO;
          r_byte_cnt <= '0;
          r_busy     <= 1'b1;
        end
      end else if (!net_busy) begin
        // One byte leaves per unstalled cycle; r_byte_cnt is the index of the
        // byte being emitted on this edge.
        r_send     <= 1'b1;
        r_byte_cnt <= r_byte_cnt + 8'd1;
        unique case (r_state)
          ST_HDR: begin
            r_out   <= header_for(r_kind);
            r_state <= (r_kind == SESS_CTRL) ? ST_CTRL_HI : ST_AUD_HI;
          end
          ST_CTRL_HI: begin
            r_out   <= r_ctrl_word[15:8];
            r_state <= ST_CTRL_LO;
          end
          ST_CTRL_LO: begin
            r_out   <= r_ctrl_word[7:0];
            r_state <= ST_PAD;
          end
          ST_AUD_HI: begin
            r_out   <= w_fifo_dout[15:8];
            r_state <= ST_AUD_LO;
          end
          ST_AUD_LO: begin
            r_out   <= w_fifo_dout[7:0];
            r_state <= (r_byte_cnt == LAST_AUD_LO) ? ST_PAD : ST_AUD_HI;
          end
          ST_PAD: begin
            r_out <= 8'h00;
            if (r_byte_cnt == LAST_BYTE) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl_ready  = r_ctrl_ready;
  assign audio_ready = !w_fifo_full;
  assign send_signal = r_send;
  assign packet_out  = r_out;
  assign busy        = r_busy;

endmodule

// File: tb/tb_transport_send.sv
// Self-checking bench for transport_send: directed scenarios with random data,
// checked against packets built from the wire-format rules.
module tb_transport_send;

  localparam int PS    = 16;
  localparam int AW    = (PS - 2) / 2;
  localparam int DEPTH = 16;

  logic        clk         = 1'b0;
  logic        reset       = 1'b0;
  logic        ctrl_valid  = 1'b0;
  logic [15:0] ctrl_data   = '0;
  logic        audio_valid = 1'b0;
  logic [15:0] audio_data  = '0;
  logic        net_busy    = 1'b0;
  logic        ctrl_ready;
  logic        audio_ready;
  logic        send_signal;
  logic [7:0]  packet_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  got_q[$];
  int          got_cyc[$];
  logic [7:0]  exp_q[$];
  logic [15:0] aud_model[$];

  transport_send #(
    .PACKET_SIZE (PS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_valid  (ctrl_valid),
    .ctrl_data   (ctrl_data),
    .ctrl_ready  (ctrl_ready),
    .audio_valid (audio_valid),
    .audio_data  (audio_data),
    .audio_ready (audio_ready),
    .net_busy    (net_busy),
    .send_signal (send_signal),
    .packet_out  (packet_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (reset && send_signal) begin
      got_q.push_back(packet_out);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic void add_ctrl_pkt(input logic [15:0] w);
    exp_q.push_back(8'h40);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    for (int i = 3; i < PS; i++) exp_q.push_back(8'h00);
  endfunction

  function automatic void add_audio_pkt();
    logic [15:0] w;
    exp_q.push_back(8'h80);
    for (int i = 0; i < AW; i++) begin
      w = aud_model.pop_front();
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    for (int i = 1 + 2 * AW; i < PS; i++) exp_q.push_back(8'h00);
  endfunction

  task automatic send_ctrl(input logic [15:0] w);
    ctrl_data  = w;
    ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
  endtask

  task automatic push_audio(input logic [15:0] w);
    bit acc;
    acc = (aud_model.size() < DEPTH);
    check("audio_ready before push", audio_ready, acc);
    audio_data  = w;
    audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    if (acc) aud_model.push_back(w);
  endtask

  task automatic wait_bytes(input string tag, input int n_bytes, input int budget);
    int n;
    n = 0;
    while (got_q.size() < n_bytes && n < budget) begin
      step();
      n++;
    end
    check({tag, " wait timeout"}, n < budget, 1'b1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((got_q.size() < exp_q.size() || busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, " drain timeout"}, n < budget, 1'b1);
    repeat (20) step();
    check({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] c;
    logic [15:0] w;
    int          run;

    // Reset state
    repeat (3) step();
    check("rst send_signal", send_signal, 1'b0);
    check("rst packet_out", packet_out, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst ctrl_ready", ctrl_ready, 1'b1);
    check("rst audio_ready", audio_ready, 1'b1);
    reset = 1'b1;
    step();

    // Control packet: latency, contiguity, ctrl_ready return
    send_ctrl(16'h1234);
    check("ctrl_ready after accept", ctrl_ready, 1'b0);
    check("busy at accept", busy, 1'b0);
    step();
    check("busy before header", busy, 1'b1);
    check("send before header", send_signal, 1'b0);
    step();
    check("header send", send_signal, 1'b1);
    check("header byte", packet_out, 8'h40);
    run = 1;
    for (int i = 1; i < PS; i++) begin
      step();
      if (send_signal) run++;
      if (i == 1) check("ctrl_ready during CTRL_HI", ctrl_ready, 1'b0);
      if (i == 2) check("ctrl_ready after CTRL_LO", ctrl_ready, 1'b1);
    end
    check("ctrl consecutive sends", run, PS);
    step();
    check("send after packet", send_signal, 1'b0);
    check("busy after packet", busy, 1'b0);
    add_ctrl_pkt(16'h1234);
    drain("ctrl", 100);

    // Audio: 6 words must not start a packet, the 7th does
    for (int i = 0; i < AW - 1; i++) push_audio({8'(2 * i + 1), 8'(2 * i + 2)});
    repeat (30) step();
    check("partial audio no bytes", got_q.size(), 0);
    check("partial audio not busy", busy, 1'b0);
    push_audio(16'h0D0E);
    add_audio_pkt();
    drain("audio", 100);

    // Audio with random data and random backpressure
    for (int i = 0; i < AW; i++) push_audio(16'($urandom));
    add_audio_pkt();
    for (int n = 0; n < 200 && got_q.size() < exp_q.size(); n++) begin
      net_busy = 1'($urandom_range(0, 1));
      step();
    end
    net_busy = 1'b0;
    drain("audio rand bp", 100);

    // Priority: control and 7th audio word accepted on the same edge
    for (int i = 0; i < AW - 1; i++) push_audio(16'($urandom));
    c = 16'($urandom);
    w = 16'($urandom);
    check("audio_ready before prio push", audio_ready, 1'b1);
    ctrl_data   = c;
    ctrl_valid  = 1'b1;
    audio_data  = w;
    audio_valid = 1'b1;
    step();
    ctrl_valid  = 1'b0;
    audio_valid = 1'b0;
    aud_model.push_back(w);
    add_ctrl_pkt(c);
    add_audio_pkt();
    wait_bytes("prio", 2 * PS, 200);
    if (got_q.size() >= 2 * PS) begin
      check("prio ctrl contiguous", got_cyc[PS-1] - got_cyc[0], PS - 1);
      check("prio one idle gap", got_cyc[PS] - got_cyc[PS-1], 2);
      check("prio audio contiguous", got_cyc[2*PS-1] - got_cyc[PS], PS - 1);
    end
    drain("prio", 100);

    // Backpressure: 3 stalled cycles after byte 5
    c = 16'($urandom);
    send_ctrl(c);
    add_ctrl_pkt(c);
    wait_bytes("bp", 5, 50);
    net_busy = 1'b1;
    step();
    check("bp stall send", send_signal, 1'b0);
    check("bp stall held byte", packet_out, exp_q[4]);
    repeat (2) step();
    net_busy = 1'b0;
    wait_bytes("bp", PS, 100);
    if (got_q.size() >= PS) check("bp span", got_cyc[PS-1] - got_cyc[0], PS - 1 + 3);
    drain("bp", 100);

    // FIFO full: 17 pushes while the network is busy
    net_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) push_audio(16'($urandom));
    check("audio_ready when full", audio_ready, 1'b0);
    check("busy frozen in header", busy, 1'b1);
    check("no bytes while net busy", got_q.size(), 0);
    add_audio_pkt();
    add_audio_pkt();
    net_busy = 1'b0;
    drain("fifo full", 200);

    // Reset mid-packet (two leftover words remain in the FIFO here)
    c = 16'($urandom);
    send_ctrl(c);
    wait_bytes("mid rst", 5, 50);
    reset = 1'b0;
    #1;
    check("mid rst send_signal", send_signal, 1'b0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst packet_out", packet_out, 8'h00);
    check("mid rst ctrl_ready", ctrl_ready, 1'b1);
    check("mid rst audio_ready", audio_ready, 1'b1);
    aud_model.delete();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < AW - 2; i++) push_audio(16'($urandom));
    repeat (30) step();
    check("fifo cleared by reset", got_q.size(), 0);
    c = 16'($urandom);
    send_ctrl(c);
    add_ctrl_pkt(c);
    drain("post rst ctrl", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transport_send.md
# transport_send

Transmit-side transport packetizer. It accepts 16-bit control words and 16-bit audio samples from the session layer and frames them into fixed-size byte packets. It streams those packets one byte per cycle toward the network interface. Packets use the same wire format the receive-side transport parser consumes: header byte, big-endian payload words, zero padding.

## Interface
Parameters:
- PACKET_SIZE, 16, packet length in bytes; even, ≥ 4
- FIFO_DEPTH, 16, audio word FIFO depth; power of two, ≥ AUDIO_WORDS
- Derived: AUDIO_WORDS = (PACKET_SIZE−2)/2 (7 at default)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- ctrl_valid  input  1  control word offered
- ctrl_data  input  16  control word
- ctrl_ready  output  1  pending-control register empty
- audio_valid  input  1  audio sample offered
- audio_data  input  16  audio sample
- audio_ready  output  1  audio FIFO not full
- net_busy  input  1  network cannot take a byte this cycle
- send_signal  output  1  packet_out valid this cycle (one byte)
- packet_out  output  8  packet byte
- busy  output  1  packet in progress (state ≠ IDLE)

## Operation
- Control accept: ctrl_valid && ctrl_ready at an edge loads the pending register. ctrl_ready goes low the next cycle and returns high the cycle after CTRL_LO is emitted.
- Audio accept: audio_valid && audio_ready pushes into the FIFO. A simultaneous push and pop leaves count unchanged. A push while full is ignored (audio_ready is already 0).
- Control packet: 0x40, ctrl_data[15:8], ctrl_data[7:0], then PACKET_SIZE−3 bytes of 0x00.
- Audio packet: 0x80, then AUDIO_WORDS words popped in order, each high byte then low byte, then one 0x00 pad byte.
- Arbitration happens only in IDLE. A pending control word wins. Otherwise an audio packet starts when FIFO count ≥ AUDIO_WORDS. A partial audio packet is never sent.
- FSM states:
  - IDLE → HDR, when a start condition holds.
  - HDR → CTRL_HI or AUD_HI.
  - CTRL_HI → CTRL_LO → PAD.
  - AUD_HI → AUD_LO. AUD_LO pops one word, then goes to AUD_HI, or to PAD after the AUDIO_WORDS-th word.
  - PAD: emits zeros until the byte counter reaches PACKET_SIZE, then → IDLE.
- Byte counter is an 8-bit register, cleared on entry to HDR and incremented per emitted byte. An 8-bit counter bounds PACKET_SIZE ≤ 255.
- Reset mid-packet: the packet is truncated, no further bytes are sent, and the FIFO and pending register are cleared.

## Timing
- Reset values: send_signal=0, packet_out=0x00, busy=0, ctrl_ready=1, audio_ready=1, state IDLE, FIFO empty.
- All outputs are registered.
- The start condition is sampled in IDLE at edge k; the state moves to HDR and busy=1 after edge k.
- Each edge in a non-IDLE state with net_busy=0: emit one byte (send_signal=1, packet_out=byte) and advance.
- Each edge with net_busy=1: send_signal=0, packet_out held, state and counters frozen.
- With net_busy low throughout, a packet occupies exactly PACKET_SIZE consecutive send_signal cycles. The first byte appears after edge k+1.
- Minimum gap between packets: 1 idle cycle.
- Control latency: ctrl_valid accepted at edge a in IDLE → header byte after edge a+2.
- Audio pop occurs at the edge that emits the low byte.

## Structure
- Shared package `transport_pkg`:
  - HDR_CTRL=8'h40, HDR_AUDIO=8'h80
  - default PACKET_SIZE=16
  - session strobe codes 2'b01 (control) and 2'b10 (audio)
- Sub-module `audio_word_fifo`:
  - synchronous FIFO, 16-bit wide, FIFO_DEPTH deep
  - ports: push, pop, dout, count, full, empty
  - same clk/reset
  - first-word-fall-through, so dout is valid while count>0

## Test plan
- Control only: ctrl_data=0x1234, net_busy=0 → bytes 40 12 34, then 13×00, send_signal high for 16 consecutive cycles, ctrl_ready back to 1.
- Audio: push 0x0102…0x0D0E (7 words) → 80 01 02 03 04 … 0D 0E 00. With only 6 words pushed, no packet is sent.
- Priority: 7 audio words queued and a control word accepted in the same cycle → the control packet is sent first, then the audio packet, with 1 idle cycle between.
- Backpressure: net_busy high for 3 cycles mid-packet → exactly 3 send_signal gaps, no byte lost or duplicated, total still 16 bytes.
- FIFO full: push 17 words with net_busy=1 held → audio_ready=0 after the 16th; the 17th word is never emitted; the first two audio packets carry words 1–7 and 8–14.
- Reset mid-packet: assert reset after byte 5 → send_signal=0 immediately, busy=0, FIFO empty. After release, a new control packet is framed correctly.
